// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, DMEM slave FSM encodings,
// and the address range helper used by the slave decode.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_PART = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // True when addr falls inside [base, base + depth_words*4).
   // Addresses below base wrap to a huge offset and fall out of range.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth_words);
      logic [32:0] span;
      logic [32:0] off;
      span = 33'(depth_words) << 2;
      off  = {1'b0, addr - base};
      return off < span;
   endfunction

endpackage

// File: rtl/axi4_lite_dmem_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and DMEM (slave).
interface axi4_lite_dmem_slave_if;

   logic [31:0] S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;

   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;

   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;

   logic [31:0] S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;

   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

endinterface

// File: rtl/axi_dmem_ram.sv
// Word-organised data memory: one byte-enabled synchronous write port and
// one synchronous read port. A same-edge read of the word being written
// returns the old contents. No reset on the array or read register.
module axi_dmem_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane write under the enable mask.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read register only updates on a read strobe, so data stays stable while held.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi4_lite_dmem_slave.sv
// AXI4-Lite DMEM responder: independent write and read FSMs in front of
// axi_dmem_ram, with byte strobes and SLVERR on out-of-range offsets.
module axi4_lite_dmem_slave
   import axi4_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input logic                   clk,
   input logic                   rst_n,
   axi4_lite_dmem_slave_if.slave s_axi
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   // Write side state
   w_state_t      w_state;
   logic          aw_held, w_held;
   logic [AW-1:0] aw_idx;
   logic          aw_ok;
   logic [31:0]   w_data;
   logic [3:0]    w_strb;
   logic          awready_q, wready_q, bvalid_q;
   logic [1:0]    bresp_q;

   // Read side state
   r_state_t      r_state;
   logic          arready_q, rvalid_q, r_err;
   logic [1:0]    rresp_q;
   logic [31:0]   ram_rdata;

   logic [31:0]   aw_off, ar_off;
   logic          aw_hs, w_hs, ar_hs, ar_ok, commit;
   logic          unused_bits;

   assign aw_off = s_axi.S_AXI_AWADDR - BASE_ADDR;
   assign ar_off = s_axi.S_AXI_ARADDR - BASE_ADDR;
   assign ar_ok  = addr_in_range(s_axi.S_AXI_ARADDR, BASE_ADDR, DEPTH_WORDS);

   assign aw_hs  = s_axi.S_AXI_AWVALID && awready_q;
   assign w_hs   = s_axi.S_AXI_WVALID  && wready_q;
   assign ar_hs  = s_axi.S_AXI_ARVALID && arready_q;

   // Both halves held: the commit edge, which is also the edge BVALID rises.
   assign commit = aw_held && w_held;

   assign unused_bits = ^{aw_off[31:AW+2], aw_off[1:0], ar_off[31:AW+2], ar_off[1:0],
                          s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   // Write FSM: capture AW and W independently, commit once both are held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_idx    <= '0;
         aw_ok     <= 1'b0;
         w_data    <= '0;
         w_strb    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE, W_PART: begin
               if (commit) begin
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  w_state   <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held <= 1'b1;
                     aw_idx  <= aw_off[AW+1:2];
                     aw_ok   <= addr_in_range(s_axi.S_AXI_AWADDR, BASE_ADDR, DEPTH_WORDS);
                  end
                  if (w_hs) begin
                     w_held <= 1'b1;
                     w_data <= s_axi.S_AXI_WDATA;
                     w_strb <= s_axi.S_AXI_WSTRB;
                  end
                  awready_q <= !(aw_held || aw_hs);
                  wready_q  <= !(w_held || w_hs);
                  if (aw_held || w_held || aw_hs || w_hs) w_state <= W_PART;
               end
            end
            W_RESP: begin
               if (s_axi.S_AXI_BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: AR handshake launches the array read; response held until RREADY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                  r_err     <= !ar_ok;
                  r_state   <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.S_AXI_RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   axi_dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (commit && aw_ok && (w_state != W_RESP)),
      .be    (w_strb),
      .waddr (aw_idx),
      .wdata (w_data),
      .re    (ar_hs && ar_ok),
      .raddr (ar_off[AW+1:2]),
      .rdata (ram_rdata)
   );

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   // The array has no reset, so RDATA is forced to zero unless an in-range response is pending.
   assign s_axi.S_AXI_RDATA   = (rvalid_q && !r_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi4_lite_dmem_slave.sv
// Directed bench for axi4_lite_dmem_slave with hand-computed expectations.
module tb_axi4_lite_dmem_slave;
   import axi4_lite_pkg::*;

   logic clk;
   logic rst_n;
   int unsigned passed;
   int unsigned total;
   int unsigned fails;

   axi4_lite_dmem_slave_if bus();

   axi4_lite_dmem_slave #(
      .BASE_ADDR   (32'h1000_0000),
      .DEPTH_WORDS (1024)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_axi (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input string tag);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_WVALID  = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      check({tag, "_bvalid_early"}, 32'(bus.S_AXI_BVALID), 32'd0);
      @(negedge clk);
      check({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
      check({tag, "_bresp"}, 32'(bus.S_AXI_BRESP), 32'(resp));
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      check({tag, "_bvalid_clr"}, 32'(bus.S_AXI_BVALID), 32'd0);
      check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
      check({tag, "_wready"}, 32'(bus.S_AXI_WREADY), 32'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input string tag);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      check({tag, "_rvalid"}, 32'(bus.S_AXI_RVALID), 32'd1);
      check({tag, "_rdata"}, bus.S_AXI_RDATA, data);
      check({tag, "_rresp"}, 32'(bus.S_AXI_RRESP), 32'(resp));
      check({tag, "_arready_busy"}, 32'(bus.S_AXI_ARREADY), 32'd0);
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      check({tag, "_rvalid_clr"}, 32'(bus.S_AXI_RVALID), 32'd0);
      check({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWPROT  = 3'b010;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARPROT  = 3'b101;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;

      // Reset held for three cycles
      repeat (3) @(negedge clk);
      check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
      check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
      check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
      check("rst_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
      check("rst_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
      check("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      check("rel_wready",  32'(bus.S_AXI_WREADY),  32'd1);
      check("rel_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

      // Aligned full-word write then read
      do_write(32'h1000_0010, 32'hA5A5_1234, 4'hF, RESP_OKAY, "wr_full");
      do_read(32'h1000_0010, 32'hA5A5_1234, RESP_OKAY, "rd_full");

      // W two cycles ahead of AW, strobes on bytes 0 and 2
      bus.S_AXI_WDATA  = 32'hFFFF_FFFF;
      bus.S_AXI_WSTRB  = 4'b0101;
      bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_WVALID = 1'b0;
      check("wfirst_wready", 32'(bus.S_AXI_WREADY), 32'd0);
      check("wfirst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      @(negedge clk);
      check("wfirst_bvalid_wait", 32'(bus.S_AXI_BVALID), 32'd0);
      bus.S_AXI_AWADDR  = 32'h1000_0010;
      bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      check("wfirst_bvalid_early", 32'(bus.S_AXI_BVALID), 32'd0);
      @(negedge clk);
      check("wfirst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
      check("wfirst_bresp", 32'(bus.S_AXI_BRESP), 32'd0);
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      check("wfirst_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
      do_read(32'h1000_0010, 32'hA5FF_12FF, RESP_OKAY, "rd_strb");

      // Out of range (offset 0x1000 = 1024 words) and range edges
      do_write(32'h1000_0000, 32'h1122_3344, 4'hF, RESP_OKAY, "wr_w0");
      do_write(32'h1000_1000, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, "wr_oor");
      do_read(32'h1000_0000, 32'h1122_3344, RESP_OKAY, "rd_w0_kept");
      do_read(32'h1000_1000, 32'h0000_0000, RESP_SLVERR, "rd_oor");
      do_read(32'h0FFF_FFFC, 32'h0000_0000, RESP_SLVERR, "rd_below");
      do_write(32'h1000_0FFF, 32'h0BAD_F00D, 4'hF, RESP_OKAY, "wr_last");
      do_read(32'h1000_0FFC, 32'h0BAD_F00D, RESP_OKAY, "rd_last");
      do_write(32'h1000_0010, 32'h7777_7777, 4'h0, RESP_OKAY, "wr_nostrb");
      do_read(32'h1000_0010, 32'hA5FF_12FF, RESP_OKAY, "rd_nostrb");

      // Same-edge commit and read of one word returns the old data
      do_write(32'h1000_0030, 32'h0101_0101, 4'hF, RESP_OKAY, "wr_pre");
      bus.S_AXI_AWADDR  = 32'h1000_0030;
      bus.S_AXI_WDATA   = 32'h0202_0202;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_ARADDR  = 32'h1000_0030;
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      check("coll_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
      check("coll_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("coll_rdata", bus.S_AXI_RDATA, 32'h0101_0101);
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      do_read(32'h1000_0030, 32'h0202_0202, RESP_OKAY, "rd_coll_after");

      // Backpressure on both response channels
      bus.S_AXI_AWADDR  = 32'h1000_0020;
      bus.S_AXI_WDATA   = 32'hCAFE_F00D;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_ARADDR  = 32'h1000_0010;
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
         check("bp_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
         check("bp_rvalid",  32'(bus.S_AXI_RVALID),  32'd1);
         check("bp_rdata",   bus.S_AXI_RDATA,        32'hA5FF_12FF);
         check("bp_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
         check("bp_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
         check("bp_wready",  32'(bus.S_AXI_WREADY),  32'd0);
         check("bp_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
         @(negedge clk);
      end
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      check("bp_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
      check("bp_rvalid_clr", 32'(bus.S_AXI_RVALID), 32'd0);
      check("bp_awready_back", 32'(bus.S_AXI_AWREADY), 32'd1);
      check("bp_arready_back", 32'(bus.S_AXI_ARREADY), 32'd1);
      do_read(32'h1000_0020, 32'hCAFE_F00D, RESP_OKAY, "rd_bp");

      // Reset between AW and W drops the held address
      bus.S_AXI_AWADDR  = 32'h1000_0010;
      bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      check("midrst_awready_held", 32'(bus.S_AXI_AWREADY), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_awready_rst", 32'(bus.S_AXI_AWREADY), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_awready_rel", 32'(bus.S_AXI_AWREADY), 32'd1);
      check("midrst_wready_rel", 32'(bus.S_AXI_WREADY), 32'd1);
      bus.S_AXI_WDATA  = 32'h0000_0000;
      bus.S_AXI_WSTRB  = 4'hF;
      bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("midrst_no_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
         @(negedge clk);
      end
      do_read(32'h1000_0010, 32'hA5FF_12FF, RESP_OKAY, "rd_midrst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
